// File: rtl/key_event_sched.sv
// Key event sequencer: merges live PS/2 events and a ROM-scripted macro into one
// {strobe, release, code} stream for the keyboard matrix, buffering live events during playback.
module key_event_sched #(
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 7000000,
    parameter int MACRO_LEN   = 16
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [10:0]                  ps2_key,
    input  logic                         macro_start,
    output logic [$clog2(MACRO_LEN)-1:0] macro_addr,
    input  logic [8:0]                   macro_data,
    output logic                         macro_busy,
    output logic                         ev_strobe,
    output logic                         ev_release,
    output logic [7:0]                   ev_code,
    output logic                         fifo_overflow
);

    // state   | meaning
    // IDLE    | no macro; drain live-event FIFO one entry per cycle
    // M_FETCH | macro ROM read latency for current macro_addr
    // M_WAIT  | hold divider counting between macro steps
    // M_EMIT  | act on macro_data: end, pause or emit, then advance
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        M_FETCH = 2'd1,
        M_WAIT  = 2'd2,
        M_EMIT  = 2'd3
    } state_t;

    localparam int AW = $clog2(MACRO_LEN);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(HOLD_CYCLES + 1);

    localparam logic [AW-1:0] LAST_ADDR = AW'(MACRO_LEN - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(HOLD_CYCLES - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [8:0]    MAC_END   = 9'h0FF;
    localparam logic [8:0]    MAC_PAUSE = 9'h000;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          rel_q, rel_d;
    logic [7:0]    code_q, code_d;
    logic          ovf_q, ovf_d;
    logic          tog_q, tog_d;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic live_evt;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic unused_ext;

    assign unused_ext = ps2_key[8];

    assign live_evt   = (ps2_key[10] != tog_q);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_FULL);
    // A full FIFO still accepts an entry when the head leaves on the same edge.
    assign push       = live_evt && (!fifo_full || pop);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        rel_d    = rel_q;
        code_d   = code_q;
        pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (macro_start) begin
                    state_d = M_FETCH;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                    div_d   = '0;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    strobe_d = 1'b1;
                    rel_d    = mem_q[rd_q][8];
                    code_d   = mem_q[rd_q][7:0];
                end
            end
            M_FETCH: begin
                state_d = M_WAIT;
            end
            M_WAIT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = M_EMIT;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            M_EMIT: begin
                if (macro_data == MAC_END) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (macro_data != MAC_PAUSE) begin
                        strobe_d = 1'b1;
                        rel_d    = macro_data[8];
                        code_d   = macro_data[7:0];
                    end
                    // No wrap: running off the last ROM entry ends playback.
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = M_FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        tog_d = ps2_key[10];

        if (push) begin
            mem_d[wr_q] = {~ps2_key[9], ps2_key[7:0]};
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (PW + 1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (PW + 1)'(1);
        end
        if (live_evt && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            rel_q    <= 1'b0;
            code_q   <= 8'h00;
            ovf_q    <= 1'b0;
            tog_q    <= ps2_key[10];
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            rel_q    <= rel_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
            tog_q    <= tog_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign macro_addr    = addr_q;
    assign macro_busy    = busy_q;
    assign ev_strobe     = strobe_q;
    assign ev_release    = rel_q;
    assign ev_code       = code_q;
    assign fifo_overflow = ovf_q;

endmodule
